quad_decoder: RTL and testbench

Quadrature rotary-encoder decoder sitting directly downstream of the two `debounce` instances (channel A and channel B) in the RGB mixer. It tracks the 2-bit Gray-code phase of the debounced encoder signals, accumulates quarter-steps into whole detents, and maintains a saturating or wrapping colour-level register. That register drives the PWM stage. It also flags illegal phase jumps caused by missed samples.

---
 rtl/quad_decoder.sv | 92 +++++++++
 tb/tb_quad_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder decoder with detent accumulation and saturating/wrapping level
module quad_decoder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int INIT  = 0,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] value,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             err_pulse
);

    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;

    logic [1:0]       prev;
    logic [1:0]       cur;
    logic [1:0]       delta;
    logic             primed;
    logic signed [2:0] sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] down_val;
    logic             fwd;
    logic             rev;
    logic             bad;

    // Gray phase to ring position: 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    always_comb begin
        cur   = {a, b};
        delta = gray_pos(cur) - gray_pos(prev);
        fwd   = (delta == 2'd1);
        rev   = (delta == 2'd3);
        bad   = (delta == 2'd2);
        sum   = {1'b0, value} + STEP_EXT;
        dif   = {1'b0, value} - STEP_EXT;
        // Top bit of the extended result flags overflow (sum) or borrow (dif)
        up_val   = (WRAP != 0 || !sum[WIDTH]) ? sum[WIDTH-1:0] : MAX_VAL;
        down_val = (WRAP != 0 || !dif[WIDTH]) ? dif[WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value      <= INIT_VAL;
            prev       <= 2'b00;
            primed     <= 1'b0;
            sub        <= 3'sd0;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            prev       <= cur;
            if (!primed) begin
                primed <= 1'b1;
            end else if (fwd) begin
                if (sub == 3'sd3) begin
                    sub      <= 3'sd0;
                    up_pulse <= 1'b1;
                    value    <= up_val;
                end else begin
                    sub <= sub + 3'sd1;
                end
            end else if (rev) begin
                if (sub == -3'sd3) begin
                    sub        <= 3'sd0;
                    down_pulse <= 1'b1;
                    value      <= down_val;
                end else begin
                    sub <= sub - 3'sd1;
                end
            end else if (bad) begin
                sub       <= 3'sd0;
                err_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder across saturate/wrap configurations
module tb_quad_decoder;

    typedef struct {
        int         idx;
        logic [7:0] val;
        logic       up;
        logic       dn;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [7:0] vals [4];
    logic [3:0] ups;
    logic [3:0] dns;
    logic [3:0] errs;

    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];
    logic [1:0] ab_now = 2'b00;

    int p_step [4] = '{1, 16, 16, 16};
    int p_init [4] = '{0, 250, 250, 5};
    int p_wrap [4] = '{0, 0, 1, 0};

    int         m_val [4];
    int         m_sub [4];
    logic [1:0] m_prev [4];
    logic       m_primed [4];

    always #5 clk = ~clk;

    quad_decoder #(.WIDTH(8), .STEP(1), .INIT(0), .WRAP(0)) u_d0 (
        .clk(clk), .reset(reset), .a(a), .b(b), .value(vals[0]),
        .up_pulse(ups[0]), .down_pulse(dns[0]), .err_pulse(errs[0]));
    quad_decoder #(.WIDTH(8), .STEP(16), .INIT(250), .WRAP(0)) u_d1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .value(vals[1]),
        .up_pulse(ups[1]), .down_pulse(dns[1]), .err_pulse(errs[1]));
    quad_decoder #(.WIDTH(8), .STEP(16), .INIT(250), .WRAP(1)) u_d2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .value(vals[2]),
        .up_pulse(ups[2]), .down_pulse(dns[2]), .err_pulse(errs[2]));
    quad_decoder #(.WIDTH(8), .STEP(16), .INIT(5), .WRAP(0)) u_d3 (
        .clk(clk), .reset(reset), .a(a), .b(b), .value(vals[3]),
        .up_pulse(ups[3]), .down_pulse(dns[3]), .err_pulse(errs[3]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ring_idx(input logic [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ring_code(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_step(input int i, input logic r, input logic [1:0] ab);
        exp_t e;
        int   d;
        e.idx = i; e.up = 1'b0; e.dn = 1'b0; e.err = 1'b0;
        if (r) begin
            m_val[i] = p_init[i]; m_sub[i] = 0; m_prev[i] = 2'b00; m_primed[i] = 1'b0;
        end else if (!m_primed[i]) begin
            m_prev[i] = ab; m_primed[i] = 1'b1;
        end else begin
            d = (ring_idx(ab) - ring_idx(m_prev[i]) + 4) % 4;
            if (d == 1) begin
                if (m_sub[i] == 3) begin
                    m_sub[i] = 0; e.up = 1'b1;
                    m_val[i] = m_val[i] + p_step[i];
                    if (m_val[i] > 255) m_val[i] = (p_wrap[i] != 0) ? m_val[i] - 256 : 255;
                end else m_sub[i]++;
            end else if (d == 3) begin
                if (m_sub[i] == -3) begin
                    m_sub[i] = 0; e.dn = 1'b1;
                    m_val[i] = m_val[i] - p_step[i];
                    if (m_val[i] < 0) m_val[i] = (p_wrap[i] != 0) ? m_val[i] + 256 : 0;
                end else m_sub[i]--;
            end else if (d == 2) begin
                m_sub[i] = 0; e.err = 1'b1;
            end
            m_prev[i] = ab;
        end
        e.val = m_val[i][7:0];
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic [1:0] ab);
        exp_t e;
        reset = r; a = ab[1]; b = ab[0]; ab_now = ab;
        for (int i = 0; i < 4; i++) model_step(i, r, ab);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_empty observed=0 expected=entry");
            end else begin
                e = sb.pop_front();
                check_eq($sformatf("value%0d", e.idx), 32'(vals[e.idx]), 32'(e.val));
                check_eq($sformatf("up%0d", e.idx), 32'(ups[e.idx]), 32'(e.up));
                check_eq($sformatf("down%0d", e.idx), 32'(dns[e.idx]), 32'(e.dn));
                check_eq($sformatf("err%0d", e.idx), 32'(errs[e.idx]), 32'(e.err));
            end
        end
    endtask

    task automatic seq(input logic [15:0] codes, input int n);
        for (int k = 0; k < n; k++) step(1'b0, codes[2*(n-1-k) +: 2]);
    endtask

    task automatic check_vals(input string tag, input int v0, input int v1, input int v2, input int v3);
        check_eq({tag, "_d0"}, 32'(vals[0]), 32'(v0));
        check_eq({tag, "_d1"}, 32'(vals[1]), 32'(v1));
        check_eq({tag, "_d2"}, 32'(vals[2]), 32'(v2));
        check_eq({tag, "_d3"}, 32'(vals[3]), 32'(v3));
    endtask

    initial begin
        int r;
        int p;
        @(posedge clk);
        #1;
        // reset and priming at 11
        step(1'b1, 2'b11); step(1'b1, 2'b11);
        step(1'b0, 2'b11); step(1'b0, 2'b11); step(1'b0, 2'b11);
        check_vals("prime", 0, 250, 250, 5);

        // two clockwise detents from 00
        step(1'b1, 2'b00); step(1'b0, 2'b00);
        seq(16'b01_11_10_00, 4);
        check_vals("cw1", 1, 255, 10, 21);
        seq(16'b01_11_10_00, 4);
        check_vals("cw2", 2, 255, 26, 37);

        // reversal mid-detent
        seq(16'b01_11_01_00, 4);
        check_vals("rev", 2, 255, 26, 37);

        // illegal jump then forward walk relative to 11
        step(1'b0, 2'b11);
        seq(16'b10_00_01_11_10_00, 6);
        check_vals("illegal", 3, 255, 42, 53);

        // counter-clockwise detent from INIT
        step(1'b1, 2'b00); step(1'b0, 2'b00);
        seq(16'b10_11_01_00, 4);
        check_vals("ccw", 0, 234, 234, 0);

        // reset mid-detent discards quarter-steps
        step(1'b1, 2'b00); step(1'b0, 2'b00);
        seq(16'b01_11_10, 3);
        step(1'b1, 2'b10); step(1'b0, 2'b10);
        seq(16'b00_01_11, 3);
        check_vals("rst_mid", 0, 250, 250, 5);

        // random walk with occasional illegal jumps and resets
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            p = ring_idx(ab_now);
            if (r < 8)       step(1'b0, ring_code(p + 1));
            else if (r < 14) step(1'b0, ring_code(p + 3));
            else if (r < 17) step(1'b0, ab_now);
            else if (r < 19) step(1'b0, ring_code(p + 2));
            else             step(1'b1, ab_now);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
